// File: rtl/sb_tx_pkg.sv
// sb_tx_pkg: shared types and constants for the sideband TX message scheduler.
//   sb_tx_state_e  scheduler FSM state (IDLE, LOAD, SEND)
//   SYNC_BYTE      first byte of every packet
//   RESERVED_CODE  message code that is never transmitted
//   pkt_byte()     packet byte at a given index
package sb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } sb_tx_state_e;

  localparam logic [7:0]  SYNC_BYTE     = 8'hA5;
  localparam int unsigned RESERVED_CODE = 0;

  // Packet layout: sync, code, zero padding, tail byte at last_idx.
  function automatic logic [7:0] pkt_byte(input int unsigned idx,
                                          input int unsigned last_idx,
                                          input logic [7:0]  code_byte,
                                          input logic [7:0]  tail_byte);
    if (idx == 0)             return SYNC_BYTE;
    else if (idx == 1)        return code_byte;
    else if (idx == last_idx) return tail_byte;
    else                      return 8'h00;
  endfunction

endpackage

// File: rtl/sb_tx_fifo.sv
// sb_tx_fifo: synchronous FIFO holding pending message codes.
// Read data is show-ahead (head entry visible while not empty).
// A write while full is accepted only when a read happens in the same cycle.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wr_en, wr_data    write request and data
//   rd_en, rd_data    pop request and head entry
//   full, empty       occupancy flags
module sb_tx_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Pointers carry an extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage; no reset needed, contents are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sb_tx_msg_scheduler.sv
// sb_tx_msg_scheduler: captures sideband message codes on rising edges of
// i_msg_valid, queues them and serializes each as a PKT_BYTES packet.
// Optional macro SB_TX_CHECKSUM_EN: last byte is the XOR of all earlier
// bytes; otherwise the last byte is 8'h00.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_msg_valid           level valid from the handshake wrapper
//   i_encoded_SB_msg      message code
//   i_sb_ready            link accepts the current byte
//   o_sb_data, o_sb_valid packet byte stream
//   o_SB_Busy             message pending or being sent
//   o_falling_edge_busy   one-cycle pulse when busy falls
//   o_overflow            one-cycle pulse when a message is dropped
module sb_tx_msg_scheduler #(
  parameter int unsigned SB_MSG_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PKT_BYTES    = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_encoded_SB_msg,
  input  logic                    i_sb_ready,
  output logic [7:0]              o_sb_data,
  output logic                    o_sb_valid,
  output logic                    o_SB_Busy,
  output logic                    o_falling_edge_busy,
  output logic                    o_overflow
);

  import sb_tx_pkg::*;

  localparam int unsigned         IDX_W    = $clog2(PKT_BYTES);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(PKT_BYTES - 1);

  sb_tx_state_e            state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d, nxt_idx;
  logic [7:0]              code_q, code_d;
  logic [7:0]              data_d;
  logic                    valid_d;
  logic [7:0]              tail_byte;
  logic                    valid_q;
  logic                    cap_valid;
  logic [SB_MSG_WIDTH-1:0] cap_code;
  logic                    wr_req;
  logic                    pop;
  logic [SB_MSG_WIDTH-1:0] fifo_data;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    busy;
  logic                    busy_prev;

  // Rising-edge capture of the level valid; registered one cycle before the FIFO write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q   <= 1'b0;
      cap_valid <= 1'b0;
      cap_code  <= '0;
    end else begin
      valid_q   <= i_msg_valid;
      cap_valid <= i_msg_valid && !valid_q;
      cap_code  <= i_encoded_SB_msg;
    end
  end

  assign wr_req = cap_valid && (cap_code != SB_MSG_WIDTH'(RESERVED_CODE));

  sb_tx_fifo #(
    .WIDTH (SB_MSG_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (wr_req),
    .wr_data (cap_code),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef SB_TX_CHECKSUM_EN
  // Padding bytes are zero, so the XOR reduces to sync ^ code.
  assign tail_byte = SYNC_BYTE ^ code_q;
`else
  assign tail_byte = 8'h00;
`endif

  assign nxt_idx = idx_q + IDX_W'(1);

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    code_d  = code_q;
    data_d  = o_sb_data;
    valid_d = o_sb_valid;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = LOAD;
      end
      LOAD: begin
        pop     = 1'b1;
        code_d  = 8'(fifo_data);
        idx_d   = '0;
        data_d  = SYNC_BYTE;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (i_sb_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            data_d  = 8'h00;
            valid_d = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d  = nxt_idx;
            data_d = pkt_byte(32'(nxt_idx), PKT_BYTES - 1, code_q, tail_byte);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and pulse registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      code_q     <= 8'h00;
      o_sb_data  <= 8'h00;
      o_sb_valid <= 1'b0;
      o_overflow <= 1'b0;
      busy_prev  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      code_q     <= code_d;
      o_sb_data  <= data_d;
      o_sb_valid <= valid_d;
      o_overflow <= wr_req && fifo_full && !pop;
      busy_prev  <= busy;
    end
  end

  // Busy and its falling edge are decoded from registered state only.
  assign busy                = !fifo_empty || (state_q != IDLE);
  assign o_SB_Busy           = busy;
  assign o_falling_edge_busy = busy_prev && !busy;

endmodule
